// File: rtl/store_sequence_checker_if.sv
// rtl/store_sequence_checker_if.sv - store bus and table config bus for store_sequence_checker
interface store_sequence_checker_if #(
  parameter int WIDTH = 32,
  parameter int IW    = 3
);
  logic             mem_write;
  logic [WIDTH-1:0] data_adr;
  logic [WIDTH-1:0] write_data;
  logic             cfg_we;
  logic [IW-1:0]    cfg_idx;
  logic             cfg_kind;
  logic [WIDTH-1:0] cfg_adr;
  logic [WIDTH-1:0] cfg_data;

  modport master (
    output mem_write, data_adr, write_data,
    output cfg_we, cfg_idx, cfg_kind, cfg_adr, cfg_data
  );

  modport slave (
    input mem_write, data_adr, write_data,
    input cfg_we, cfg_idx, cfg_kind, cfg_adr, cfg_data
  );
endinterface

// File: rtl/store_sequence_checker.sv
// rtl/store_sequence_checker.sv - ordered store-sequence monitor with allow list and timeout
module store_sequence_checker #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1000,
  localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IW:0]           len,
  store_sequence_checker_if.slave bus,
  output logic                  busy,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic [IW-1:0]         fail_idx,
  output logic [WIDTH-1:0]      fail_adr,
  output logic [WIDTH-1:0]      fail_data,
  output logic [IW:0]           match_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  // NONE doubles as the saturated length and the "no further EXPECT" sentinel.
  localparam logic [IW:0] NONE    = (IW + 1)'(DEPTH);
  localparam logic [31:0] CNT_LIM = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  logic             tbl_kind [DEPTH];
  logic [WIDTH-1:0] tbl_adr  [DEPTH];
  logic [WIDTH-1:0] tbl_data [DEPTH];

  state_t           state_q, state_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             timeout_q, timeout_d;
  logic [IW-1:0]    fail_idx_q, fail_idx_d;
  logic [WIDTH-1:0] fail_adr_q, fail_adr_d;
  logic [WIDTH-1:0] fail_data_q, fail_data_d;
  logic [IW:0]      match_q, match_d;
  logic [IW:0]      len_q, len_d;
  logic [IW-1:0]    cur_q, cur_d;
  logic [31:0]      cnt_q, cnt_d;

  logic [IW:0]      len_sat;
  logic [IW:0]      first_exp;
  logic [IW:0]      next_exp;
  logic             allow_hit;
  logic             decided;

  function automatic logic [IW:0] find_exp(input logic [IW:0] from, input logic [IW:0] lim);
    logic [IW:0] r;
    r = NONE;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (i >= int'(from) && i < int'(lim) && !tbl_kind[i]) r = (IW + 1)'(i);
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_kind[i] <= 1'b0;
        tbl_adr[i]  <= '0;
        tbl_data[i] <= '0;
      end
    end else if (bus.cfg_we && state_q != S_RUN && !start && int'(bus.cfg_idx) < DEPTH) begin
      tbl_kind[bus.cfg_idx] <= bus.cfg_kind;
      tbl_adr[bus.cfg_idx]  <= bus.cfg_adr;
      tbl_data[bus.cfg_idx] <= bus.cfg_data;
    end
  end

  always_comb begin
    len_sat   = (int'(len) > DEPTH) ? NONE : len;
    first_exp = find_exp('0, len_sat);
    next_exp  = find_exp({1'b0, cur_q} + 1'b1, len_q);
    allow_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(len_q) && tbl_kind[i] && tbl_adr[i] == bus.data_adr) allow_hit = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    timeout_d   = timeout_q;
    fail_idx_d  = fail_idx_q;
    fail_adr_d  = fail_adr_q;
    fail_data_d = fail_data_q;
    match_d     = match_q;
    len_d       = len_q;
    cur_d       = cur_q;
    cnt_d       = cnt_q;
    decided     = 1'b0;
    case (state_q)
      S_RUN: begin
        cnt_d = cnt_q + 32'd1;
        if (bus.mem_write) begin
          if (bus.data_adr == tbl_adr[cur_q] && bus.write_data == tbl_data[cur_q]) begin
            match_d = match_q + 1'b1;
            if (next_exp == NONE) begin
              state_d = S_PASS;
              pass_d  = 1'b1;
              decided = 1'b1;
            end else begin
              cur_d = next_exp[IW-1:0];
            end
          end else if (bus.data_adr == tbl_adr[cur_q] || !allow_hit) begin
            // An address hit on the current entry with wrong data is fatal even if also allowed.
            state_d     = S_FAIL;
            fail_d      = 1'b1;
            fail_idx_d  = cur_q;
            fail_adr_d  = bus.data_adr;
            fail_data_d = bus.write_data;
            decided     = 1'b1;
          end
        end
        if (!decided && TIMEOUT != 0 && cnt_q == CNT_LIM) begin
          state_d     = S_FAIL;
          fail_d      = 1'b1;
          timeout_d   = 1'b1;
          fail_idx_d  = cur_q;
          fail_adr_d  = '0;
          fail_data_d = '0;
        end
      end
      default: begin
        if (start) begin
          pass_d      = 1'b0;
          fail_d      = 1'b0;
          timeout_d   = 1'b0;
          fail_idx_d  = '0;
          fail_adr_d  = '0;
          fail_data_d = '0;
          match_d     = '0;
          len_d       = len_sat;
          cnt_d       = '0;
          if (first_exp == NONE) begin
            state_d = S_PASS;
            pass_d  = 1'b1;
          end else begin
            state_d = S_RUN;
            cur_d   = first_exp[IW-1:0];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_idx_q  <= '0;
      fail_adr_q  <= '0;
      fail_data_q <= '0;
      match_q     <= '0;
      len_q       <= '0;
      cur_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
      fail_idx_q  <= fail_idx_d;
      fail_adr_q  <= fail_adr_d;
      fail_data_q <= fail_data_d;
      match_q     <= match_d;
      len_q       <= len_d;
      cur_q       <= cur_d;
      cnt_q       <= cnt_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign timeout   = timeout_q;
  assign fail_idx  = fail_idx_q;
  assign fail_adr  = fail_adr_q;
  assign fail_data = fail_data_q;
  assign match_cnt = match_q;

endmodule
